// File: rtl/sys_math_pkg.sv
// Shared definitions for the sys_divq divider.
//   state_t  : controller states IDLE -> PREP -> RUN -> FIX
//   negate64 : two's-complement negation on a 64-bit container
//   abs64    : magnitude of a 64-bit two's-complement value
// Callers sign- or zero-extend into 64 bits and size-cast the result
// back to their own width, so one pair of helpers serves every width.
package sys_math_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic logic [63:0] negate64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // The most-negative value maps onto itself, which read as unsigned
    // is exactly its magnitude.
    function automatic logic [63:0] abs64(input logic [63:0] v);
        return v[63] ? negate64(v) : v;
    endfunction

endpackage

// File: rtl/sys_divq_step.sv
// One restoring-division step (purely combinational).
//   rem_in  / rem_out : partial remainder, NB_DIV+1 bits
//   quo_in  / quo_out : dividend/quotient shift register, NB_NUM bits
//   dvs               : divisor magnitude, NB_DIV bits
// The dividend MSB is shifted into the partial remainder; if the result
// is at least the divisor it is reduced and a 1 is shifted into the
// quotient, otherwise a 0.
module sys_divq_step #(
    parameter int NB_NUM = 32,
    parameter int NB_DIV = 16
) (
    input  logic [NB_DIV:0]   rem_in,
    input  logic [NB_NUM-1:0] quo_in,
    input  logic [NB_DIV-1:0] dvs,
    output logic [NB_DIV:0]   rem_out,
    output logic [NB_NUM-1:0] quo_out
);

    logic [NB_DIV+1:0] shifted;
    logic              take;

    always_comb begin
        shifted = {rem_in, quo_in[NB_NUM-1]};
        take    = (shifted >= {2'b00, dvs});
        // shifted < 2*dvs, so the reduced value always fits NB_DIV+1 bits
        rem_out = take ? (shifted[NB_DIV:0] - {1'b0, dvs}) : shifted[NB_DIV:0];
        quo_out = {quo_in[NB_NUM-2:0], take};
    end

endmodule

// File: rtl/sys_divq.sv
// Multi-cycle restoring divider: result = num / div, remainder = num % div.
// Optional macro SYS_DIVQ_SIGNED_EN adds the signed_op port and
// two's-complement handling (quotient truncated toward zero, remainder
// takes the dividend's sign). Without it the divider is unsigned only.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   start, num, div : request pulse and operands (sampled together in IDLE)
//   signed_op       : signed-mode select (SYS_DIVQ_SIGNED_EN only)
//   busy, done      : operation in progress / one-cycle result strobe
//   result, remainder, div0 : outputs, held until the next done
// Latency start->done is NB_NUM+3 edges, or 2 edges for a zero divisor.
module sys_divq
    import sys_math_pkg::*;
#(
    parameter int NB_NUM = 32,
    parameter int NB_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NB_NUM-1:0] num,
    input  logic [NB_DIV-1:0] div,
`ifdef SYS_DIVQ_SIGNED_EN
    input  logic              signed_op,
`endif
    output logic              busy,
    output logic              done,
    output logic [NB_NUM-1:0] result,
    output logic [NB_DIV-1:0] remainder,
    output logic              div0
);

    localparam int CW = $clog2(NB_NUM + 1);
    // RUN spends one extra cycle at count == NB_NUM to hand over to FIX,
    // which is why the counter must be able to hold NB_NUM itself.
    localparam logic [CW-1:0] CNT_LAST = CW'(NB_NUM);

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg;
    logic [NB_NUM-1:0] num_reg;
    logic [NB_DIV-1:0] div_reg;
    logic [NB_NUM-1:0] quo_reg;
    logic [NB_DIV:0]   rem_reg;
    logic [NB_DIV-1:0] dmag_reg;
    logic              zero_reg;
    logic              done_reg, div0_reg;
    logic [NB_NUM-1:0] result_reg;
    logic [NB_DIV-1:0] remainder_reg;

    logic [NB_NUM-1:0] num_mag, quo_step, res_fix;
    logic [NB_DIV-1:0] div_mag, rem_fix;
    logic [NB_DIV:0]   rem_step;

`ifdef SYS_DIVQ_SIGNED_EN
    logic signed_reg, num_neg_reg, div_neg_reg;
`endif

    sys_divq_step #(.NB_NUM(NB_NUM), .NB_DIV(NB_DIV)) u_step (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .dvs     (dmag_reg),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = (div_reg == '0) ? FIX : RUN;
            RUN:     if (count_reg == CNT_LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand magnitudes for PREP and sign-corrected outputs for FIX.
    always_comb begin
`ifdef SYS_DIVQ_SIGNED_EN
        num_mag = signed_reg ? NB_NUM'(abs64(64'($signed(num_reg)))) : num_reg;
        div_mag = signed_reg ? NB_DIV'(abs64(64'($signed(div_reg)))) : div_reg;
        res_fix = (num_neg_reg ^ div_neg_reg) ? NB_NUM'(negate64(64'(quo_reg))) : quo_reg;
        rem_fix = num_neg_reg ? NB_DIV'(negate64(64'(rem_reg[NB_DIV-1:0])))
                              : rem_reg[NB_DIV-1:0];
`else
        num_mag = num_reg;
        div_mag = div_reg;
        res_fix = quo_reg;
        rem_fix = rem_reg[NB_DIV-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            num_reg       <= '0;
            div_reg       <= '0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            dmag_reg      <= '0;
            zero_reg      <= 1'b0;
            done_reg      <= 1'b0;
            div0_reg      <= 1'b0;
            result_reg    <= '0;
            remainder_reg <= '0;
`ifdef SYS_DIVQ_SIGNED_EN
            signed_reg    <= 1'b0;
            num_neg_reg   <= 1'b0;
            div_neg_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        num_reg    <= num;
                        div_reg    <= div;
`ifdef SYS_DIVQ_SIGNED_EN
                        signed_reg <= signed_op;
`endif
                    end
                end
                PREP: begin
                    quo_reg   <= num_mag;
                    rem_reg   <= '0;
                    dmag_reg  <= div_mag;
                    count_reg <= '0;
                    zero_reg  <= (div_reg == '0);
`ifdef SYS_DIVQ_SIGNED_EN
                    num_neg_reg <= signed_reg & num_reg[NB_NUM-1];
                    div_neg_reg <= signed_reg & div_reg[NB_DIV-1];
`endif
                end
                RUN: begin
                    if (count_reg != CNT_LAST) begin
                        quo_reg   <= quo_step;
                        rem_reg   <= rem_step;
                        count_reg <= count_reg + 1'b1;
                    end
                end
                FIX: begin
                    done_reg <= 1'b1;
                    div0_reg <= zero_reg;
                    if (zero_reg) begin
                        result_reg    <= '1;
                        remainder_reg <= num_reg[NB_DIV-1:0];
                    end else begin
                        result_reg    <= res_fix;
                        remainder_reg <= rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign result    = result_reg;
    assign remainder = remainder_reg;
    assign div0      = div0_reg;

endmodule

// File: tb/tb_sys_divq.sv
// Directed bench for sys_divq: a 32/16 instance for directed vectors and
// a random sweep, plus an 8/8 instance for a small-width random sweep.
// Signed vectors are applied only when SYS_DIVQ_SIGNED_EN is defined.
module tb_sys_divq;

    localparam int LAT32 = 35;
    localparam int LAT8  = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] num;
    logic [15:0] div;
    logic        signed_op;
    logic        busy, done, div0;
    logic [31:0] result;
    logic [15:0] remainder;

    logic        start8;
    logic [7:0]  num8, div8;
    logic        signed_op8;
    logic        busy8, done8, div08;
    logic [7:0]  result8, remainder8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sys_divq #(.NB_NUM(32), .NB_DIV(16)) dut (
        .clk(clk), .reset(reset), .start(start), .num(num), .div(div),
`ifdef SYS_DIVQ_SIGNED_EN
        .signed_op(signed_op),
`endif
        .busy(busy), .done(done), .result(result), .remainder(remainder), .div0(div0)
    );

    sys_divq #(.NB_NUM(8), .NB_DIV(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .num(num8), .div(div8),
`ifdef SYS_DIVQ_SIGNED_EN
        .signed_op(signed_op8),
`endif
        .busy(busy8), .done(done8), .result(result8), .remainder(remainder8), .div0(div08)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for done on the 32/16 instance; 'already' edges have elapsed
    // since the start edge. Busy must be high until done and low with it.
    task automatic wait_done(input int already, output int lat, output logic prot_ok);
        lat = 0;
        prot_ok = (busy === 1'b1);
        for (int k = already + 1; k <= already + 200; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                if (busy !== 1'b0) prot_ok = 1'b0;
                break;
            end else if (busy !== 1'b1) begin
                prot_ok = 1'b0;
            end
        end
    endtask

    // Drives start immediately (so consecutive calls are back-to-back in
    // the done cycle) and returns at the cycle done is observed.
    task automatic do_op(input logic [31:0] n, input logic [15:0] d, input logic s,
                         output int lat, output logic prot_ok);
        num = n; div = d; signed_op = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0, lat, prot_ok);
    endtask

    task automatic do_op8(input logic [7:0] n, input logic [7:0] d, input logic s,
                          output int lat);
        num8 = n; div8 = d; signed_op8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // One directed unsigned vector with full output checks.
    task automatic dir_u(input string tag, input logic [31:0] n, input logic [15:0] d,
                         input logic [31:0] q, input logic [15:0] r, input int lat_exp,
                         input logic z);
        int lat;
        logic ok;
        do_op(n, d, 1'b0, lat, ok);
        $display("op %s: num=%h div=%h -> result=%h remainder=%h div0=%b latency=%0d",
                 tag, n, d, result, remainder, div0, lat);
        check({tag, ".latency"}, 64'(lat), 64'(lat_exp));
        check({tag, ".busy"}, 64'(ok), 64'd1);
        check({tag, ".result"}, 64'(result), 64'(q));
        check({tag, ".remainder"}, 64'(remainder), 64'(r));
        check({tag, ".div0"}, 64'(div0), 64'(z));
    endtask

    initial begin
        int lat;
        logic ok;
        int dones;
        logic [31:0] n;
        logic [15:0] d;
        logic [7:0] n8, d8;
        longint lhs, rhs, rs, ds;

        reset = 1'b1; start = 1'b0; num = '0; div = '0; signed_op = 1'b0;
        start8 = 1'b0; num8 = '0; div8 = '0; signed_op8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("reset: busy=%b done=%b result=%h remainder=%h div0=%b",
                 busy, done, result, remainder, div0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.result", 64'(result), 64'd0);
        check("rst.remainder", 64'(remainder), 64'd0);
        check("rst.div0", 64'(div0), 64'd0);

        // Directed unsigned vectors, issued back-to-back in the done cycle.
        dir_u("u100000_7", 32'd100000, 16'd7, 32'd14285, 16'd5, LAT32, 1'b0);
        dir_u("div0", 32'd1234, 16'd0, 32'hFFFF_FFFF, 16'h04D2, 2, 1'b1);
        dir_u("max_1", 32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, LAT32, 1'b0);
        dir_u("max_max", 32'hFFFF_FFFF, 16'hFFFF, 32'd65537, 16'd0, LAT32, 1'b0);
        dir_u("small", 32'd5, 16'd9, 32'd0, 16'd5, LAT32, 1'b0);
        dir_u("u123456789", 32'd123456789, 16'd10000, 32'd12345, 16'd6789, LAT32, 1'b0);

        // Outputs hold after done while idle.
        repeat (5) @(posedge clk);
        #1;
        $display("hold: result=%h remainder=%h div0=%b", result, remainder, div0);
        check("hold.result", 64'(result), 64'd12345);
        check("hold.remainder", 64'(remainder), 64'd6789);

        // A start pulse during RUN is ignored.
        @(negedge clk);
        num = 32'd100000; div = 16'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        num = 32'd5; div = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(11, lat, ok);
        $display("op busy_start: result=%h remainder=%h latency=%0d", result, remainder, lat);
        check("busy_start.latency", 64'(lat), 64'(LAT32));
        check("busy_start.result", 64'(result), 64'd14285);
        check("busy_start.remainder", 64'(remainder), 64'd5);

        // Reset asserted in RUN cycle 10 abandons the operation.
        @(negedge clk);
        num = 32'd100000; div = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("mid_reset: busy=%b done=%b result=%h remainder=%h div0=%b",
                 busy, done, result, remainder, div0);
        check("mid_reset.busy", 64'(busy), 64'd0);
        check("mid_reset.done", 64'(done), 64'd0);
        check("mid_reset.result", 64'(result), 64'd0);
        check("mid_reset.remainder", 64'(remainder), 64'd0);
        dones = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check("mid_reset.no_done", 64'(dones), 64'd0);
        dir_u("after_reset", 32'd100000, 16'd7, 32'd14285, 16'd5, LAT32, 1'b0);

`ifdef SYS_DIVQ_SIGNED_EN
        do_op(32'hFFFF_FFF9, 16'd2, 1'b1, lat, ok);
        $display("op s_m7_2: result=%h remainder=%h latency=%0d", result, remainder, lat);
        check("s_m7_2.latency", 64'(lat), 64'(LAT32));
        check("s_m7_2.result", 64'(result), 64'hFFFF_FFFD);
        check("s_m7_2.remainder", 64'(remainder), 64'hFFFF);
        do_op(32'h8000_0000, 16'hFFFF, 1'b1, lat, ok);
        $display("op s_min_m1: result=%h remainder=%h div0=%b", result, remainder, div0);
        check("s_min_m1.result", 64'(result), 64'h8000_0000);
        check("s_min_m1.remainder", 64'(remainder), 64'h0);
        check("s_min_m1.div0", 64'(div0), 64'd0);
        do_op(32'd7, 16'hFFFE, 1'b1, lat, ok);
        $display("op s_7_m2: result=%h remainder=%h", result, remainder);
        check("s_7_m2.result", 64'(result), 64'hFFFF_FFFD);
        check("s_7_m2.remainder", 64'(remainder), 64'h1);
        do_op(32'hFFFE_7960, 16'd7, 1'b1, lat, ok);
        $display("op s_m100000_7: result=%h remainder=%h", result, remainder);
        check("s_m100000_7.result", 64'(result), 64'hFFFF_C833);
        check("s_m100000_7.remainder", 64'(remainder), 64'hFFFB);
`endif

        // Random sweep at 32/16: identity and remainder bound.
        for (int i = 0; i < 16; i++) begin
            n = $urandom;
            d = 16'($urandom_range(1, 65535));
            do_op(n, d, 1'b0, lat, ok);
            $display("op rnd32u: num=%h div=%h -> result=%h remainder=%h", n, d, result, remainder);
            lhs = longint'({32'd0, n});
            rhs = longint'({32'd0, result}) * longint'({48'd0, d}) + longint'({48'd0, remainder});
            check("rnd32u.identity", 64'(rhs), 64'(lhs));
            check("rnd32u.bound", 64'(remainder < d), 64'd1);
        end
`ifdef SYS_DIVQ_SIGNED_EN
        for (int i = 0; i < 16; i++) begin
            n = $urandom;
            d = 16'($urandom_range(1, 65535));
            if (n == 32'h8000_0000 && d == 16'hFFFF) d = 16'd3;
            do_op(n, d, 1'b1, lat, ok);
            $display("op rnd32s: num=%h div=%h -> result=%h remainder=%h", n, d, result, remainder);
            lhs = longint'($signed(n));
            ds  = longint'($signed(d));
            rs  = longint'($signed(remainder));
            rhs = longint'($signed(result)) * ds + rs;
            check("rnd32s.identity", 64'(rhs), 64'(lhs));
            check("rnd32s.bound", 64'(((rs < 0) ? -rs : rs) < ((ds < 0) ? -ds : ds)), 64'd1);
            check("rnd32s.rsign", 64'((rs == 0) || ((rs < 0) == (lhs < 0))), 64'd1);
        end
`endif

        // Random sweep at 8/8.
        for (int i = 0; i < 16; i++) begin
            n8 = 8'($urandom);
            d8 = 8'($urandom_range(1, 255));
            do_op8(n8, d8, 1'b0, lat);
            $display("op rnd8u: num=%h div=%h -> result=%h remainder=%h latency=%0d",
                     n8, d8, result8, remainder8, lat);
            check("rnd8u.latency", 64'(lat), 64'(LAT8));
            rhs = longint'({56'd0, result8}) * longint'({56'd0, d8}) + longint'({56'd0, remainder8});
            check("rnd8u.identity", 64'(rhs), 64'(n8));
            check("rnd8u.bound", 64'(remainder8 < d8), 64'd1);
        end
`ifdef SYS_DIVQ_SIGNED_EN
        for (int i = 0; i < 16; i++) begin
            n8 = 8'($urandom);
            d8 = 8'($urandom_range(1, 255));
            if (n8 == 8'h80 && d8 == 8'hFF) d8 = 8'd5;
            do_op8(n8, d8, 1'b1, lat);
            $display("op rnd8s: num=%h div=%h -> result=%h remainder=%h", n8, d8, result8, remainder8);
            lhs = longint'($signed(n8));
            ds  = longint'($signed(d8));
            rs  = longint'($signed(remainder8));
            rhs = longint'($signed(result8)) * ds + rs;
            check("rnd8s.identity", 64'(rhs), 64'(lhs));
            check("rnd8s.bound", 64'(((rs < 0) ? -rs : rs) < ((ds < 0) ? -ds : ds)), 64'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sys_divq.md
SYS_DIVQ -- requirements
Module: sys_divq

Interface
REQ-001 SHALL have parameter NB_NUM, default 32: dividend and quotient width, legal range 2..64.
REQ-002 SHALL have parameter NB_DIV, default 16: divisor and remainder width, legal range 2..NB_NUM.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request pulse; operands are sampled on the same edge.
REQ-006 SHALL have port num, input, NB_NUM: dividend.
REQ-007 SHALL have port div, input, NB_DIV: divisor.
REQ-008 SHALL have port signed_op, input, 1: two's-complement mode select, sampled with start (present only when the REQ-030 macro is defined).
REQ-009 SHALL have port busy, output, 1: an operation is in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking result, remainder and div0 valid.
REQ-011 SHALL have port result, output, NB_NUM: quotient.
REQ-012 SHALL have port remainder, output, NB_DIV: remainder.
REQ-013 SHALL have port div0, output, 1: the last operation had a zero divisor.

Function
REQ-014 SHALL implement the FSM IDLE -> PREP -> RUN -> FIX -> IDLE, one state per cycle except RUN.
REQ-015 SHALL accept start only in IDLE; start while busy is ignored and operands are not resampled.
REQ-016 SHALL assert busy from the edge after an accepted start until the edge on which done rises; busy and done are never high together.
REQ-017 SHALL, in PREP, take operand magnitudes, latch the operand signs and detect div==0.
REQ-018 SHALL, in RUN, perform one restoring step per cycle for exactly NB_NUM cycles, using a counter sized $clog2(NB_NUM+1).
REQ-019 SHALL, in FIX, apply sign correction and drive result, remainder and div0, then pulse done for one cycle.
REQ-020 SHALL have a latency of NB_NUM+3 edges from the start edge to the edge raising done; back-to-back start is accepted in the done cycle.
REQ-021 SHALL, when div==0, skip RUN (PREP -> FIX) with done at start+2 edges, result all ones, remainder = num[NB_DIV-1:0] and div0=1.
REQ-022 SHALL, in signed mode, truncate the quotient toward zero, give the remainder the dividend's sign, and satisfy num == result*div + remainder.
REQ-023 SHALL, in signed mode, return result = most-negative value and remainder=0 for num = most-negative and div = -1, with div0=0.
REQ-024 SHALL hold result, remainder and div0 stable from done until the next accepted start produces a new done.
REQ-025 SHALL size the internal partial remainder at NB_DIV+1 bits so that no step overflows.

Reset
REQ-026 SHALL, on reset, return the FSM to IDLE and clear busy, done, div0, result, remainder and the step counter to 0.
REQ-027 SHALL, when reset is asserted mid-operation, abandon the operation with no done pulse.
REQ-028 SHALL give reset priority over start when both are high.

Configuration
REQ-029 SHALL treat unsigned division as the baseline behaviour.
REQ-030 SHALL, with SYS_DIVQ_SIGNED_EN defined, add the signed_op port and the sign handling of REQ-017, REQ-022 and REQ-023.
REQ-031 SHALL, without SYS_DIVQ_SIGNED_EN, omit signed_op, always divide unsigned, and add no sign logic.

Structure
REQ-032 SHALL place the state enum (IDLE/PREP/RUN/FIX) and the abs/negate helper functions in package sys_math_pkg.
REQ-033 SHALL implement the combinational trial-subtract/shift in a sub-module sys_divq_step instantiated once.

Verification
REQ-034 SHALL cover unsigned 32/16: num=100000, div=7 -> done at start+35, result=14285, remainder=5.
REQ-035 SHALL cover div0: num=1234, div=0 -> done at start+2, result=FFFFFFFF, remainder=04D2, div0=1.
REQ-036 SHALL cover signed: num=-7, div=2 -> result=-3, remainder=-1; and num=80000000, div=FFFF -> result=80000000, remainder=0.
REQ-037 SHALL cover start pulsed during RUN -> ignored, and the original result is delivered unchanged.
REQ-038 SHALL cover reset at RUN cycle 10 -> busy=0 next cycle, no done, all outputs 0; a new start then completes normally.
REQ-039 SHALL cover a random sweep at NB_NUM=8, NB_DIV=8 and at the defaults -> the REQ-022 identity holds and |remainder| < |div|.
